lfsr_gen: RTL
=============

Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator, the successor of the fixed 1-bit-per-cycle LFSR.
- Adds the following over that block:
  - a configurable tap polynomial;
  - multi-bit advance per enable;
  - a runtime seed load with zero-seed protection;
  - a start-up state machine with a valid flag.
- Used as a stimulus and noise source for test benches and as a scrambler or dither source in FPGA projects.

Parameters:
- Width, 5, LFSR state width; legal range 3..32.
- Taps, 5'b10100, feedback mask; bit i set means q[i] joins the XOR. The default is x^5+x^3+1, which is maximal-length.
- Seed, 5'b00001, reset/default state; must be non-zero.
- Step, 1, number of single shifts per enabled cycle; legal range 1..Width.

Ports:
- clk_i, input, 1, single system clock, rising edge.
- rst_ni, input, 1, reset; synchronous and active-low.
- en_i, input, 1, advance the LFSR by Step shifts this cycle.
- load_i, input, 1, load seed_i into the state.
- seed_i, input, Width, runtime seed value.
- q_o, output, Width, current LFSR state (registered).
- rnd_o, output, Step, random output bits; equal to q_o[Width-1 -: Step].
- valid_o, output, 1, high once the state has been advanced at least once since reset or load.
- seed_err_o, output, 1, one-cycle pulse when a zero seed was loaded.
- wrap_o, output, 1, one-cycle pulse when the state returns to its start value (optional feature only).

Behaviour:
- Single shift:
  - fb = XOR over i of (q[i] & Taps[i]).
  - q_next = {q[Width-2:0], fb}.
- Enabled cycle: applies the single shift Step times combinationally, unrolled. The top Step bits of the old state are the bits shifted out, and they are presented on rnd_o before the edge.
- Reset: when rst_ni=0 at a rising edge:
  - q_o=Seed;
  - FSM=IDLE;
  - valid_o=0, seed_err_o=0, wrap_o=0;
  - start register=Seed;
  - period counter=0.
- Priority at each edge: reset > load_i > en_i > hold.
- Load:
  - If seed_i!=0: q_o=seed_i and start=seed_i.
  - If seed_i==0: q_o=Seed, start=Seed, and seed_err_o=1 for exactly the next cycle.
  - Every load goes to IDLE, clears valid_o, and clears the counter.
  - en_i is ignored in a load cycle.
- FSM:
  - IDLE: on en_i, the state advances and the FSM goes to RUN; valid_o=1 from the following cycle.
  - RUN: advances on en_i and holds otherwise; a load returns to IDLE.
- Lockup: the all-zero state is unreachable by construction. If q_o is ever observed as 0 in RUN (SEU, X-init), the next edge forces q_o=Seed and pulses seed_err_o; this has no effect on valid_o.
- en_i low: q_o, rnd_o and valid_o hold, with no pulses.
- Deasserting reset mid-sequence discards all state; there is no memory of the prior sequence.
- All outputs are registered, except rnd_o, which is a bit-select of the register.

Optional Feature:
- Macro: LFSR_GEN_PERIOD_EN.
- With the macro defined:
  - a Width-bit step counter increments on each enabled cycle;
  - when the post-advance state equals the start register, wrap_o pulses for 1 cycle (registered, aligned with the new q_o) and the counter clears to 0;
  - the counter is cleared by reset and load.
- Without the macro: no counter or start comparator is synthesised, and wrap_o is tied to 0.

Test Plan:
- Reset, then 5 enables, with defaults (Width=5, Taps=10100, Step=1):
  - q_o goes 00001, 00010, 00100, 01001, 10010, 00101;
  - valid_o=0 before the first enable and 1 after it.
- load_i=1 with seed_i=10110 and en_i=1 in the same cycle: q_o=10110 (the enable is ignored), valid_o=0, seed_err_o=0.
- load_i=1 with seed_i=00000: q_o=00001 and seed_err_o is high for exactly one cycle.
- Step=2 with defaults, 1 enable from 00001: q_o=00100 and rnd_o=00 before the edge.
- With LFSR_GEN_PERIOD_EN defined, 31 consecutive enables from 00001:
  - all 31 non-zero states are visited once;
  - q_o returns to 00001 and wrap_o pulses on that cycle;
  - the counter reads 0 afterwards.
- rst_ni=0 for 1 cycle in the middle of RUN with en_i=1: the next q_o=00001, valid_o=0, and no wrap_o or seed_err_o pulse.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with multi-bit advance, seed load,
// zero-seed protection and a start-up FSM; optional wrap detect via LFSR_GEN_PERIOD_EN.
module lfsr_gen #(
    parameter int unsigned      Width = 5,
    parameter logic [Width-1:0] Taps  = 5'b10100,
    parameter logic [Width-1:0] Seed  = 5'b00001,
    parameter int unsigned      Step  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [Width-1:0] seed_i,
    output logic [Width-1:0] q_o,
    output logic [Step-1:0]  rnd_o,
    output logic             valid_o,
    output logic             seed_err_o,
    output logic             wrap_o
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_n;
    logic [Width-1:0] q, q_n, adv;
    logic             valid, valid_n;
    logic             err, err_n;

    // Step single shifts, unrolled into one combinational cone.
    function automatic logic [Width-1:0] advance(input logic [Width-1:0] s);
        logic [Width-1:0] t;
        t = s;
        for (int i = 0; i < int'(Step); i++) begin
            t = {t[Width-2:0], ^(t & Taps)};
        end
        return t;
    endfunction

    assign adv = advance(q);

`ifdef LFSR_GEN_PERIOD_EN
    logic [Width-1:0] start, start_n;
    logic [Width-1:0] cnt, cnt_n;
    logic             wrap, wrap_n;
`endif

    // Next-state: load beats lockup recovery, which beats advance, which beats hold.
    always_comb begin
        state_n = state;
        q_n     = q;
        err_n   = 1'b0;
`ifdef LFSR_GEN_PERIOD_EN
        start_n = start;
        cnt_n   = cnt;
        wrap_n  = 1'b0;
`endif
        if (load_i) begin
            state_n = IDLE;
            if (seed_i != '0) begin
                q_n = seed_i;
            end else begin
                q_n   = Seed;
                err_n = 1'b1;
            end
`ifdef LFSR_GEN_PERIOD_EN
            start_n = q_n;
            cnt_n   = '0;
`endif
        end else if (state == RUN && q == '0) begin
            q_n   = Seed;
            err_n = 1'b1;
        end else if (en_i) begin
            q_n     = adv;
            state_n = RUN;
`ifdef LFSR_GEN_PERIOD_EN
            if (adv == start) begin
                wrap_n = 1'b1;
                cnt_n  = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
`endif
        end
        valid_n = (state_n == RUN);
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and flag registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q     <= Seed;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            q     <= q_n;
            valid <= valid_n;
            err   <= err_n;
        end
    end

`ifdef LFSR_GEN_PERIOD_EN
    // Start value, period counter and wrap pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            start <= Seed;
            cnt   <= '0;
            wrap  <= 1'b0;
        end else begin
            start <= start_n;
            cnt   <= cnt_n;
            wrap  <= wrap_n;
        end
    end

    assign wrap_o = wrap;
`else
    assign wrap_o = 1'b0;
`endif

    assign q_o        = q;
    assign rnd_o      = q[Width-1 -: Step];
    assign valid_o    = valid;
    assign seed_err_o = err;

endmodule
